// File: rtl/vtg_pkg.sv
// Shared types and standard timing sets for the video timing generator.
// Timing fields are FIELD_BITS wide; generator counters may be narrower (X_BITS/Y_BITS <= FIELD_BITS).
package vtg_pkg;

    localparam int FIELD_BITS = 16;

    typedef logic [FIELD_BITS-1:0] field_t;

    typedef struct packed {
        field_t h_total;
        field_t h_sync;
        field_t h_bp;
        field_t h_act;
        field_t v_total;
        field_t v_sync;
        field_t v_bp;
        field_t v_act;
    } timing_t;

    typedef enum logic [1:0] {
        STOP  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } run_state_t;

    localparam timing_t VTG_1080P = '{
        h_total: 16'd2200, h_sync: 16'd44, h_bp: 16'd148, h_act: 16'd1920,
        v_total: 16'd1125, v_sync: 16'd5,  v_bp: 16'd36,  v_act: 16'd1080
    };

    localparam timing_t VTG_720P = '{
        h_total: 16'd1650, h_sync: 16'd40, h_bp: 16'd220, h_act: 16'd1280,
        v_total: 16'd750,  v_sync: 16'd5,  v_bp: 16'd20,  v_act: 16'd720
    };

    localparam timing_t VTG_480P = '{
        h_total: 16'd858,  h_sync: 16'd62, h_bp: 16'd60,  h_act: 16'd720,
        v_total: 16'd525,  v_sync: 16'd6,  v_bp: 16'd30,  v_act: 16'd480
    };

endpackage

// File: rtl/vtg_cfg_shadow.sv
// Pending timing slot with valid/ready intake and frame-boundary copy into the active set.
// With TIMING_CHECK_EN defined, illegal timings are dropped at copy time and flagged on cfg_err.
module vtg_cfg_shadow
    import vtg_pkg::*;
#(
    parameter timing_t DEF_TIMING = VTG_1080P
`ifdef TIMING_CHECK_EN
    , parameter int unsigned PRE_LEAD = 2
`endif
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    running,
    input  logic    last_pixel,
    input  logic    cfg_valid,
    input  timing_t cfg_in,
    output logic    cfg_ready,
    output timing_t active,
    output logic    cfg_err
);

    timing_t pend;
    logic    pend_full;
    logic    copy_now;
    logic    cfg_ok;

    assign cfg_ready = !pend_full;
    // While stopped there is no frame to protect, so the copy happens right away.
    assign copy_now  = pend_full && (!running || last_pixel);

`ifdef TIMING_CHECK_EN
    logic [FIELD_BITS+1:0] h_used;
    logic [FIELD_BITS+1:0] v_used;
    logic [FIELD_BITS+1:0] h_lead;

    assign h_used = {2'b00, pend.h_sync} + {2'b00, pend.h_bp} + {2'b00, pend.h_act};
    assign v_used = {2'b00, pend.v_sync} + {2'b00, pend.v_bp} + {2'b00, pend.v_act};
    assign h_lead = {2'b00, pend.h_sync} + {2'b00, pend.h_bp};

    assign cfg_ok = (pend.h_sync != '0) && (pend.h_act != '0)
                 && (h_used < {2'b00, pend.h_total})
                 && (pend.v_sync != '0) && (pend.v_act != '0)
                 && (v_used < {2'b00, pend.v_total})
                 && (h_lead >= (FIELD_BITS+2)'(PRE_LEAD));

    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= copy_now && !cfg_ok;
        end
    end
`else
    assign cfg_ok  = 1'b1;
    assign cfg_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            active    <= DEF_TIMING;
            pend      <= '0;
            pend_full <= 1'b0;
        end else begin
            if (copy_now) begin
                pend_full <= 1'b0;
                if (cfg_ok) begin
                    active <= pend;
                end
            end else if (cfg_valid && cfg_ready) begin
                pend      <= cfg_in;
                pend_full <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/video_timing_gen.sv
// Runtime-reprogrammable video timing generator: HS/VS/DE, early DE, active coordinates, strobes.
// Optional config validation is enabled with the TIMING_CHECK_EN macro.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   STOP  | counters held at (0,0), outputs inactive, waiting for en
//   RUN   | counting frames continuously
//   DRAIN | en dropped; finish the current frame, then STOP
module video_timing_gen
    import vtg_pkg::*;
#(
    parameter int unsigned X_BITS      = 12,
    parameter int unsigned Y_BITS      = 12,
    parameter int unsigned DEF_H_TOTAL = VTG_1080P.h_total,
    parameter int unsigned DEF_H_SYNC  = VTG_1080P.h_sync,
    parameter int unsigned DEF_H_BP    = VTG_1080P.h_bp,
    parameter int unsigned DEF_H_ACT   = VTG_1080P.h_act,
    parameter int unsigned DEF_V_TOTAL = VTG_1080P.v_total,
    parameter int unsigned DEF_V_SYNC  = VTG_1080P.v_sync,
    parameter int unsigned DEF_V_BP    = VTG_1080P.v_bp,
    parameter int unsigned DEF_V_ACT   = VTG_1080P.v_act,
    parameter bit          HS_POL      = 1'b1,
    parameter bit          VS_POL      = 1'b1,
    parameter int unsigned PRE_LEAD    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [X_BITS-1:0] cfg_h_total,
    input  logic [X_BITS-1:0] cfg_h_sync,
    input  logic [X_BITS-1:0] cfg_h_bp,
    input  logic [X_BITS-1:0] cfg_h_act,
    input  logic [Y_BITS-1:0] cfg_v_total,
    input  logic [Y_BITS-1:0] cfg_v_sync,
    input  logic [Y_BITS-1:0] cfg_v_bp,
    input  logic [Y_BITS-1:0] cfg_v_act,
    output logic              hs_out,
    output logic              vs_out,
    output logic              de_out,
    output logic              de_pre,
    output logic [X_BITS-1:0] x_act,
    output logic [Y_BITS-1:0] y_act,
    output logic              frame_start,
    output logic              line_start,
    output logic              running,
    output logic              cfg_err
);

    localparam timing_t DEF_TIMING = '{
        h_total: FIELD_BITS'(DEF_H_TOTAL), h_sync: FIELD_BITS'(DEF_H_SYNC),
        h_bp:    FIELD_BITS'(DEF_H_BP),    h_act:  FIELD_BITS'(DEF_H_ACT),
        v_total: FIELD_BITS'(DEF_V_TOTAL), v_sync: FIELD_BITS'(DEF_V_SYNC),
        v_bp:    FIELD_BITS'(DEF_V_BP),    v_act:  FIELD_BITS'(DEF_V_ACT)
    };
    localparam logic [X_BITS-1:0] X_ONE = X_BITS'(1);
    localparam logic [Y_BITS-1:0] Y_ONE = Y_BITS'(1);
    localparam logic [X_BITS-1:0] LEAD  = X_BITS'(PRE_LEAD);

    timing_t    cfg_in;
    timing_t    act;
    run_state_t state;

    logic [X_BITS-1:0] h_cnt, h_total, h_sync, h_bp, h_act;
    logic [X_BITS-1:0] h_start, h_end, pre_start, pre_end;
    logic [Y_BITS-1:0] v_cnt, v_total, v_sync, v_bp, v_act;
    logic [Y_BITS-1:0] v_start, v_end;
    logic              h_last, v_last, last_pixel;
    logic              h_in, pre_in, v_in;
    logic              unused_act;

    assign cfg_in = '{
        h_total: FIELD_BITS'(cfg_h_total), h_sync: FIELD_BITS'(cfg_h_sync),
        h_bp:    FIELD_BITS'(cfg_h_bp),    h_act:  FIELD_BITS'(cfg_h_act),
        v_total: FIELD_BITS'(cfg_v_total), v_sync: FIELD_BITS'(cfg_v_sync),
        v_bp:    FIELD_BITS'(cfg_v_bp),    v_act:  FIELD_BITS'(cfg_v_act)
    };

    vtg_cfg_shadow #(
        .DEF_TIMING (DEF_TIMING)
`ifdef TIMING_CHECK_EN
        , .PRE_LEAD (PRE_LEAD)
`endif
    ) u_shadow (
        .clk        (clk),
        .rst        (rst),
        .running    (running),
        .last_pixel (last_pixel),
        .cfg_valid  (cfg_valid),
        .cfg_in     (cfg_in),
        .cfg_ready  (cfg_ready),
        .active     (act),
        .cfg_err    (cfg_err)
    );

    // Only the low X_BITS/Y_BITS of each field drive the counters.
    assign unused_act = ^act;
    assign h_total = act.h_total[X_BITS-1:0];
    assign h_sync  = act.h_sync[X_BITS-1:0];
    assign h_bp    = act.h_bp[X_BITS-1:0];
    assign h_act   = act.h_act[X_BITS-1:0];
    assign v_total = act.v_total[Y_BITS-1:0];
    assign v_sync  = act.v_sync[Y_BITS-1:0];
    assign v_bp    = act.v_bp[Y_BITS-1:0];
    assign v_act   = act.v_act[Y_BITS-1:0];

    assign h_start   = h_sync + h_bp;
    assign h_end     = h_start + h_act - X_ONE;
    assign pre_start = h_start - LEAD;
    assign pre_end   = h_end - LEAD;
    assign v_start   = v_sync + v_bp;
    assign v_end     = v_start + v_act - Y_ONE;

    assign h_last     = (h_cnt == h_total - X_ONE);
    assign v_last     = (v_cnt == v_total - Y_ONE);
    assign last_pixel = h_last && v_last;

    assign h_in   = (h_cnt >= h_start)   && (h_cnt <= h_end);
    assign pre_in = (h_cnt >= pre_start) && (h_cnt <= pre_end);
    assign v_in   = (v_cnt >= v_start)   && (v_cnt <= v_end);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= STOP;
            running     <= 1'b0;
            h_cnt       <= '0;
            v_cnt       <= '0;
            hs_out      <= ~HS_POL;
            vs_out      <= ~VS_POL;
            de_out      <= 1'b0;
            de_pre      <= 1'b0;
            x_act       <= '0;
            y_act       <= '0;
            frame_start <= 1'b0;
            line_start  <= 1'b0;
        end else begin
            if (state == STOP) begin
                hs_out      <= ~HS_POL;
                vs_out      <= ~VS_POL;
                de_out      <= 1'b0;
                de_pre      <= 1'b0;
                x_act       <= '0;
                y_act       <= '0;
                frame_start <= 1'b0;
                line_start  <= 1'b0;
            end else begin
                hs_out      <= (h_cnt < h_sync) ? HS_POL : ~HS_POL;
                vs_out      <= (v_cnt < v_sync) ? VS_POL : ~VS_POL;
                de_out      <= h_in && v_in;
                de_pre      <= pre_in && v_in;
                x_act       <= h_in ? (h_cnt - h_start) : '0;
                y_act       <= v_in ? (v_cnt - v_start) : '0;
                frame_start <= (h_cnt == '0) && (v_cnt == '0);
                line_start  <= (h_cnt == '0);
            end

            case (state)
                STOP: begin
                    h_cnt <= '0;
                    v_cnt <= '0;
                    if (en) begin
                        state   <= RUN;
                        running <= 1'b1;
                    end
                end
                RUN, DRAIN: begin
                    h_cnt <= h_last ? '0 : h_cnt + X_ONE;
                    if (h_last) begin
                        v_cnt <= v_last ? '0 : v_cnt + Y_ONE;
                    end
                    if (en) begin
                        state <= RUN;
                    end else if (last_pixel) begin
                        state   <= STOP;
                        running <= 1'b0;
                    end else begin
                        state <= DRAIN;
                    end
                end
                default: begin
                    state   <= STOP;
                    running <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen using a small 20x12 default timing and PRE_LEAD=2.
module tb_video_timing_gen;

    logic        clk = 1'b0;
    logic        rst, en, cfg_valid;
    logic [11:0] cfg_h_total, cfg_h_sync, cfg_h_bp, cfg_h_act;
    logic [11:0] cfg_v_total, cfg_v_sync, cfg_v_bp, cfg_v_act;
    logic        cfg_ready, hs_out, vs_out, de_out, de_pre;
    logic [11:0] x_act, y_act;
    logic        frame_start, line_start, running, cfg_err;

    int checks = 0;
    int passed = 0;
    int fails  = 0;
    int cur_p  = -1;
    int err_p  = -1;

    video_timing_gen #(
        .X_BITS(12), .Y_BITS(12),
        .DEF_H_TOTAL(20), .DEF_H_SYNC(2), .DEF_H_BP(3), .DEF_H_ACT(10),
        .DEF_V_TOTAL(12), .DEF_V_SYNC(1), .DEF_V_BP(2), .DEF_V_ACT(6),
        .HS_POL(1'b1), .VS_POL(1'b1), .PRE_LEAD(2)
    ) dut (
        .clk(clk), .rst(rst), .en(en),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_h_total(cfg_h_total), .cfg_h_sync(cfg_h_sync),
        .cfg_h_bp(cfg_h_bp), .cfg_h_act(cfg_h_act),
        .cfg_v_total(cfg_v_total), .cfg_v_sync(cfg_v_sync),
        .cfg_v_bp(cfg_v_bp), .cfg_v_act(cfg_v_act),
        .hs_out(hs_out), .vs_out(vs_out), .de_out(de_out), .de_pre(de_pre),
        .x_act(x_act), .y_act(y_act),
        .frame_start(frame_start), .line_start(line_start),
        .running(running), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s at p=%0d: observed %0d expected %0d", tag, cur_p, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_cfg(input int ht, input int hact);
        cfg_h_total = 12'(ht);
        cfg_h_sync  = 12'd2;
        cfg_h_bp    = 12'd3;
        cfg_h_act   = 12'(hact);
        cfg_v_total = 12'd12;
        cfg_v_sync  = 12'd1;
        cfg_v_bp    = 12'd2;
        cfg_v_act   = 12'd6;
    endtask

    task automatic check_idle();
        chk("idle_hs", 32'(hs_out), 0);
        chk("idle_vs", 32'(vs_out), 0);
        chk("idle_de", 32'(de_out), 0);
        chk("idle_de_pre", 32'(de_pre), 0);
        chk("idle_x", 32'(x_act), 0);
        chk("idle_y", 32'(y_act), 0);
        chk("idle_fs", 32'(frame_start), 0);
        chk("idle_ls", 32'(line_start), 0);
        chk("idle_running", 32'(running), 0);
    endtask

    // Expected outputs for pixel index p of a frame with h_total=ht (sync 2, bp 3, act 10; v 12/1/2/6).
    task automatic check_px(input int p, input int ht);
        int h, v;
        logic hw, pw, vw;
        h = p % ht;
        v = (p / ht) % 12;
        hw = (h >= 5) && (h <= 14);
        pw = (h >= 3) && (h <= 12);
        vw = (v >= 3) && (v <= 8);
        cur_p = p;
        chk("hs_out", 32'(hs_out), (h < 2) ? 1 : 0);
        chk("vs_out", 32'(vs_out), (v < 1) ? 1 : 0);
        chk("de_out", 32'(de_out), (hw && vw) ? 1 : 0);
        chk("de_pre", 32'(de_pre), (pw && vw) ? 1 : 0);
        chk("x_act", 32'(x_act), hw ? h - 5 : 0);
        chk("y_act", 32'(y_act), vw ? v - 3 : 0);
        chk("frame_start", 32'(frame_start), (h == 0 && v == 0) ? 1 : 0);
        chk("line_start", 32'(line_start), (h == 0) ? 1 : 0);
    endtask

    initial begin
        rst = 1'b1;
        en = 1'b0;
        cfg_valid = 1'b0;
        set_cfg(20, 10);
        repeat (2) step();

        check_idle();
        chk("rst_cfg_ready", 32'(cfg_ready), 1);
        chk("rst_cfg_err", 32'(cfg_err), 0);

        rst = 1'b0;
        repeat (3) begin
            step();
            check_idle();
        end

        en = 1'b1;
        step();
        chk("start_running", 32'(running), 1);
        chk("start_fs_early", 32'(frame_start), 0);

        // Frames 1-2 at h_total=20; new timing offered mid frame 2.
        for (int p = 0; p < 480; p++) begin
            step();
            check_px(p, 20);
            chk("run1_running", 32'(running), 1);
            chk("run1_cfg_ready", 32'(cfg_ready), (p >= 341 && p <= 478) ? 0 : 1);
            if (p == 340) set_cfg(24, 10);
            cfg_valid = (p == 340);
        end

        // Frames 3-4 at h_total=24; en dropped, restored, then dropped for good.
        for (int p = 0; p < 576; p++) begin
            step();
            check_px(p, 24);
            chk("run2_running", 32'(running), (p == 575) ? 0 : 1);
            chk("run2_cfg_ready", 32'(cfg_ready), 1);
            if (p == 308) en = 1'b0;
            if (p == 318) en = 1'b1;
            if (p == 338) en = 1'b0;
        end

        cur_p = -1;
        repeat (3) begin
            step();
            check_idle();
        end

        // Config taken while stopped is applied on the next cycle.
        set_cfg(20, 10);
        cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
        chk("stop_cfg_ready_low", 32'(cfg_ready), 0);
        step();
        chk("stop_cfg_ready_back", 32'(cfg_ready), 1);
        check_idle();

        en = 1'b1;
        step();
        chk("restart_running", 32'(running), 1);
        chk("restart_fs_early", 32'(frame_start), 0);
        for (int p = 0; p < 60; p++) begin
            step();
            check_px(p, 20);
            chk("restart_cfg_ready", 32'(cfg_ready), (p >= 31) ? 0 : 1);
            if (p == 30) set_cfg(24, 10);
            cfg_valid = (p == 30);
        end

        // Reset mid-line with a pending config.
        rst = 1'b1;
        step();
        cur_p = -1;
        check_idle();
        chk("rst2_cfg_ready", 32'(cfg_ready), 1);
        chk("rst2_cfg_err", 32'(cfg_err), 0);
        rst = 1'b0;
        step();
        chk("rst2_running", 32'(running), 1);

`ifdef TIMING_CHECK_EN
        err_p = 239;
`endif
        for (int p = 0; p < 300; p++) begin
            step();
            check_px(p, 20);
            chk("post_rst_cfg_err", 32'(cfg_err), (p == err_p) ? 1 : 0);
`ifdef TIMING_CHECK_EN
            if (p == 100) set_cfg(20, 15);
            cfg_valid = (p == 100);
`endif
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
